// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 single-precision multiplier (radix-2 shift-add, truncating).
// Latency: out_valid rises 27 cycles after the accept edge, independent of operands.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, DONE} state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [23:0]        r_ma;        // multiplicand mantissa with hidden bit
  logic [47:0]        r_p;         // {partial sum, remaining multiplier bits}
  logic               r_sign;
  logic signed [9:0]  r_exp;       // biased exponent, wide enough for sums and the +1
  logic [4:0]         r_cnt;
  logic               r_norm_ph;   // NORM phase: 0 = normalize, 1 = classify and pack
  logic [22:0]        r_mant;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [XLEN-1:0]    r_result;
  logic               r_ovf;
  logic               r_unf;
  logic               r_exc;

  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic               w_exc;
  logic               w_zero;
  logic [24:0]        w_sum;

  assign w_ea   = r_a[30:23];
  assign w_eb   = r_b[30:23];
  assign w_exc  = (w_ea == 8'hFF) || (w_eb == 8'hFF);
  assign w_zero = (w_ea == 8'h00) || (w_eb == 8'h00);

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (LSB of r_p) is set; the caller shifts right by one.
  assign w_sum = {1'b0, r_p[47:24]} + (r_p[0] ? {1'b0, r_ma} : 25'd0);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exception = r_exc;

  // Control FSM and datapath with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_ma        <= '0;
      r_p         <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_cnt       <= '0;
      r_norm_ph   <= 1'b0;
      r_mant      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_exc       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= A;
            r_b        <= B;
            r_in_ready <= 1'b0;
            r_state    <= UNPACK;
          end
        end
        UNPACK: begin
          r_ma      <= {1'b1, r_a[22:0]};
          r_p       <= {24'd0, 1'b1, r_b[22:0]};
          r_sign    <= r_a[31] ^ r_b[31];
          r_exp     <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
          r_cnt     <= '0;
          r_state   <= MUL;
        end
        MUL: begin
          r_p <= {w_sum, r_p[23:1]};
          if (r_cnt == 5'd23) begin
            r_cnt     <= '0;
            r_norm_ph <= 1'b0;
            r_state   <= NORM;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        NORM: begin
          if (!r_norm_ph) begin
            // Product of two [1,2) mantissas lies in [1,4); truncate below the kept bits.
            if (r_p[47]) begin
              r_mant <= r_p[46:24];
              r_exp  <= r_exp + 10'sd1;
            end else begin
              r_mant <= r_p[45:23];
            end
            r_norm_ph <= 1'b1;
          end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_exc <= 1'b0;
            if (w_exc) begin
              r_result <= 32'h7FC0_0000;
              r_exc    <= 1'b1;
            end else if (w_zero) begin
              r_result <= {r_sign, 31'd0};
            end else if (r_exp >= 10'sd255) begin
              r_result <= {r_sign, 8'hFF, 23'd0};
              r_ovf    <= 1'b1;
            end else if (r_exp <= 10'sd0) begin
              r_result <= {r_sign, 31'd0};
              r_unf    <= 1'b1;
            end else begin
              r_result <= {r_sign, r_exp[7:0], r_mant};
            end
            r_norm_ph   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
